memoria_sincrona: RTL and testbench

MEMORIA_SINCRONA -- requirements
Module: memoria_sincrona

---
 rtl/memoria_pkg.sv | 12 +
 rtl/memoria_sincrona_if.sv | 26 ++
 rtl/memoria_limpeza_ctrl.sv | 71 +++++++
 rtl/memoria_sincrona.sv | 91 +++++++++
 tb/tb_memoria_sincrona.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/memoria_pkg.sv
// Shared definitions for the synchronous dual-read memory: controller state
// encoding and the number of read ports.
package memoria_pkg;

   typedef enum logic {
      ESTADO_LIMPA = 1'b0,
      ESTADO_ATIVA = 1'b1
   } estado_t;

   localparam int NUM_PORTAS = 2;

endpackage

// File: rtl/memoria_sincrona_if.sv
// Bus bundle for memoria_sincrona: write port, two read ports, clear request
// and ready flag.
interface memoria_sincrona_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
);
   logic [DATA_WIDTH-1:0] data;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic                  EscMen;
   logic [ADDR_WIDTH-1:0] read_addr_a;
   logic [ADDR_WIDTH-1:0] read_addr_b;
   logic                  limpar;
   logic [DATA_WIDTH-1:0] saida_a;
   logic [DATA_WIDTH-1:0] saida_b;
   logic                  pronto;

   modport master (
      output data, write_addr, EscMen, read_addr_a, read_addr_b, limpar,
      input  saida_a, saida_b, pronto
   );

   modport slave (
      input  data, write_addr, EscMen, read_addr_a, read_addr_b, limpar,
      output saida_a, saida_b, pronto
   );
endinterface

// File: rtl/memoria_limpeza_ctrl.sv
// Clear controller: walks cont over every address while in LIMPA, then
// settles in ATIVA with pronto high until the next clear request.
module memoria_limpeza_ctrl
   import memoria_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_limpar,
   output estado_t               o_estado,
   output logic [ADDR_WIDTH-1:0] o_cont,
   output logic                  o_pronto
);
   localparam logic [ADDR_WIDTH-1:0] ULTIMO_ENDERECO = '1;
   localparam logic [ADDR_WIDTH-1:0] UM              = ADDR_WIDTH'(1);

   estado_t               r_estado;
   estado_t               w_estado_next;
   logic [ADDR_WIDTH-1:0] r_cont;
   logic [ADDR_WIDTH-1:0] w_cont_next;
   logic                  r_pronto;
   logic                  w_pronto_next;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_estado <= ESTADO_LIMPA;
         r_cont   <= '0;
         r_pronto <= 1'b0;
      end else begin
         r_estado <= w_estado_next;
         r_cont   <= w_cont_next;
         r_pronto <= w_pronto_next;
      end
   end

   // pronto mirrors the state being entered so it is high from the first ATIVA cycle
   always_comb begin
      w_estado_next = r_estado;
      w_cont_next   = r_cont;
      w_pronto_next = r_pronto;
      case (r_estado)
         ESTADO_LIMPA: begin
            w_cont_next   = r_cont + UM;
            w_pronto_next = 1'b0;
            if (r_cont == ULTIMO_ENDERECO) begin
               w_estado_next = ESTADO_ATIVA;
               w_pronto_next = 1'b1;
            end
         end
         ESTADO_ATIVA: begin
            w_cont_next   = '0;
            w_pronto_next = 1'b1;
            if (i_limpar) begin
               w_estado_next = ESTADO_LIMPA;
               w_pronto_next = 1'b0;
            end
         end
         default: begin
            w_estado_next = ESTADO_LIMPA;
            w_cont_next   = '0;
            w_pronto_next = 1'b0;
         end
      endcase
   end

   assign o_estado = r_estado;
   assign o_cont   = r_cont;
   assign o_pronto = r_pronto;

endmodule

// File: rtl/memoria_sincrona.sv
// Synchronous RAM with one write port, two registered read ports and a
// whole-memory clear sequence. Define MEMORIA_BYPASS_EN for write-first reads.
module memoria_sincrona
   import memoria_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
) (
   input logic                clock,
   input logic                reset,
   memoria_sincrona_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_ram [DEPTH];

   estado_t               w_estado;
   logic [ADDR_WIDTH-1:0] w_cont;
   logic                  w_pronto;
   logic                  w_we;
   logic                  w_ram_we;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic [DATA_WIDTH-1:0] w_ram_din;
   logic [ADDR_WIDTH-1:0] w_raddr [NUM_PORTAS];

   memoria_limpeza_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ctrl (
      .i_clock  (clock),
      .i_reset  (reset),
      .i_limpar (bus.limpar),
      .o_estado (w_estado),
      .o_cont   (w_cont),
      .o_pronto (w_pronto)
   );

   // a write coinciding with a clear request is dropped
   assign w_we = (w_estado == ESTADO_ATIVA) && bus.EscMen && !bus.limpar;

   always_comb begin
      w_ram_we   = 1'b0;
      w_ram_addr = bus.write_addr;
      w_ram_din  = bus.data;
      if (w_estado == ESTADO_LIMPA) begin
         w_ram_we   = 1'b1;
         w_ram_addr = w_cont;
         w_ram_din  = '0;
      end else if (w_we) begin
         w_ram_we = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_ram_we) begin
         r_ram[w_ram_addr] <= w_ram_din;
      end
   end

   always_comb begin
      w_raddr[0] = bus.read_addr_a;
      w_raddr[1] = bus.read_addr_b;
   end

   for (genvar gi = 0; gi < NUM_PORTAS; gi++) begin : g_porta
      logic [DATA_WIDTH-1:0] w_leitura;
      logic [DATA_WIDTH-1:0] r_saida;

`ifdef MEMORIA_BYPASS_EN
      assign w_leitura = (w_we && (w_raddr[gi] == bus.write_addr)) ? bus.data
                                                                   : r_ram[w_raddr[gi]];
`else
      assign w_leitura = r_ram[w_raddr[gi]];
`endif

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_saida <= '0;
         end else if (w_estado == ESTADO_ATIVA) begin
            r_saida <= w_leitura;
         end else begin
            r_saida <= '0;
         end
      end
   end

   // gating by pronto keeps the outputs at zero during a clear requested from ATIVA
   assign bus.saida_a = w_pronto ? g_porta[0].r_saida : '0;
   assign bus.saida_b = w_pronto ? g_porta[1].r_saida : '0;
   assign bus.pronto  = w_pronto;

endmodule

// File: tb/tb_memoria_sincrona.sv
// Randomized self-checking bench for memoria_sincrona (ADDR_WIDTH=4,
// DATA_WIDTH=8) against an array-based model of the memory.
module tb_memoria_sincrona;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int N  = 2 ** AW;
`ifdef MEMORIA_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   memoria_sincrona_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

   memoria_sincrona #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus_if.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] m_mem [N];
   bit            m_limpando;
   int            m_rest;

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_checks++;
      if (obs !== esp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   task automatic modelo_reset();
      m_limpando = 1'b1;
      m_rest     = N;
      for (int i = 0; i < N; i++) m_mem[i] = '0;
   endtask

   // one clock cycle: drive, predict, clock, check
   task automatic passo(input string tag, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] d, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb, input logic lim);
      logic [DW-1:0] ea, eb;
      logic          ep;
      bus_if.EscMen      = we;
      bus_if.write_addr  = wa;
      bus_if.data        = d;
      bus_if.read_addr_a = ra;
      bus_if.read_addr_b = rb;
      bus_if.limpar      = lim;
      ea = '0;
      eb = '0;
      if (m_limpando) begin
         m_rest--;
         if (m_rest == 0) m_limpando = 1'b0;
         ep = !m_limpando;
      end else if (lim) begin
         modelo_reset();
         ep = 1'b0;
      end else begin
         ea = (BYPASS && we && ra == wa) ? d : m_mem[ra];
         eb = (BYPASS && we && rb == wa) ? d : m_mem[rb];
         if (we) m_mem[wa] = d;
         ep = 1'b1;
      end
      @(posedge clk);
      #1;
      $display("%s we=%0b wa=%0d d=%02h ra=%0d rb=%0d lim=%0b -> a=%02h b=%02h pronto=%0b",
               tag, we, wa, d, ra, rb, lim, bus_if.saida_a, bus_if.saida_b, bus_if.pronto);
      verifica({tag, ".saida_a"}, 32'(bus_if.saida_a), 32'(ea));
      verifica({tag, ".saida_b"}, 32'(bus_if.saida_b), 32'(eb));
      verifica({tag, ".pronto"},  32'(bus_if.pronto),  32'(ep));
   endtask

   task automatic ocioso(input string tag, input int ciclos);
      for (int i = 0; i < ciclos; i++)
         passo(tag, 1'($urandom_range(1)), 4'($urandom_range(N-1)), 8'($urandom),
               4'($urandom_range(N-1)), 4'($urandom_range(N-1)), 1'($urandom_range(1)));
   endtask

   initial begin
      int ciclos_pronto;
      bus_if.EscMen = 1'b0; bus_if.write_addr = '0; bus_if.data = '0;
      bus_if.read_addr_a = '0; bus_if.read_addr_b = '0; bus_if.limpar = 1'b0;

      // reset state
      @(posedge clk);
      #1;
      verifica("reset.saida_a", 32'(bus_if.saida_a), 32'h0);
      verifica("reset.saida_b", 32'(bus_if.saida_b), 32'h0);
      verifica("reset.pronto",  32'(bus_if.pronto),  32'h0);
      modelo_reset();
      @(negedge clk);
      rst = 1'b0;

      // initial clear: pronto must rise on exactly the 16th edge
      ciclos_pronto = 0;
      for (int i = 0; i < N; i++) begin
         passo("clear0", 1'b1, 4'($urandom_range(N-1)), 8'($urandom),
               4'($urandom_range(N-1)), 4'($urandom_range(N-1)), 1'($urandom_range(1)));
         if (bus_if.pronto === 1'b1 && ciclos_pronto == 0) ciclos_pronto = i + 1;
      end
      verifica("clear0.edges", 32'(ciclos_pronto), 32'(N));
      for (int i = 0; i < N; i++)
         passo("zero_scan", 1'b0, '0, '0, 4'(i), 4'(N-1-i), 1'b0);

      // write then read on both ports
      passo("wr_a5", 1'b1, 4'd3, 8'hA5, 4'd0, 4'd0, 1'b0);
      passo("rd_a5", 1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 1'b0);

      // read-during-write, same address on A only
      passo("rdw_5a", 1'b1, 4'd7, 8'h5A, 4'd7, 4'd3, 1'b0);
      passo("rd_5a",  1'b0, 4'd0, 8'h00, 4'd7, 4'd7, 1'b0);

      // fill, then clear with a coinciding write to addr 2
      for (int i = 0; i < N; i++)
         passo("fill", 1'b1, 4'(i), 8'($urandom_range(255, 1)), 4'($urandom_range(N-1)),
               4'(i), 1'b0);
      passo("clr_wr", 1'b1, 4'd2, 8'hFF, 4'd2, 4'd5, 1'b1);
      ocioso("clr_busy", N);
      passo("rd_addr2", 1'b0, 4'd0, 8'h00, 4'd2, 4'd9, 1'b0);

      // reset in the middle of a clear
      passo("clr_start", 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
      ocioso("clr_mid", 8);
      rst = 1'b1;
      #1;
      verifica("midrst.saida_a", 32'(bus_if.saida_a), 32'h0);
      verifica("midrst.saida_b", 32'(bus_if.saida_b), 32'h0);
      verifica("midrst.pronto",  32'(bus_if.pronto),  32'h0);
      modelo_reset();
      @(negedge clk);
      rst = 1'b0;
      ocioso("clr_again", N);
      passo("after_rst", 1'b0, 4'd0, 8'h00, 4'd1, 4'd14, 1'b0);

      // random traffic with frequent address collisions and rare clears
      for (int i = 0; i < 300; i++)
         passo("rand", 1'($urandom_range(1)), 4'($urandom_range(7)), 8'($urandom),
               4'($urandom_range(7)), 4'($urandom_range(7)), ($urandom_range(39) == 0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
